// File: rtl/ts_merge_arb.sv
// Round-robin arbiter that serializes one TS record at a time from N requesters onto a shared 33-bit bus.
// Optional statistics outputs (rec_cnt, drop_cnt) are built when TS_ARB_STAT_EN is defined.
module ts_merge_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255,
  parameter int MAX_LEN = 400,
  parameter int GAP     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  input  logic [33*N-1:0] din,
  input  logic [N-1:0]    din_en,
  output logic [32:0]     ts_dout,
  output logic            ts_dout_en,
  output logic [2:0]      cur_port,
  output logic            err
`ifdef TS_ARB_STAT_EN
  ,
  output logic [32*N-1:0] rec_cnt,
  output logic [15:0]     drop_cnt
`endif
);

  localparam int WCW = $clog2(MAX_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(GAP + 2);
  localparam logic [WCW-1:0] LEN_MAX  = WCW'(MAX_LEN);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT - 1);
  localparam logic [GCW-1:0] GAP_LAST = (GAP == 0) ? '0 : GCW'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER, ST_GAP} state_t;

  state_t         state;
  logic [2:0]     rr;
  logic [WCW-1:0] word_cnt;
  logic [TCW-1:0] wait_cnt;
  logic [GCW-1:0] gap_cnt;
  logic           trunc_done;

  // Inputs are widened to 8 lanes so a 3-bit port index always addresses them cleanly.
  logic [32:0] din_w [8];
  logic [7:0]  en_w;
  logic [7:0]  req_w;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    if (gi < N) begin : g_used
      assign din_w[gi] = din[33*gi +: 33];
      assign en_w[gi]  = din_en[gi];
      assign req_w[gi] = req[gi];
    end else begin : g_pad
      assign din_w[gi] = '0;
      assign en_w[gi]  = 1'b0;
      assign req_w[gi] = 1'b0;
    end
  end

  logic [32:0] sel_word;
  logic        sel_en;
  assign sel_word = din_w[cur_port];
  assign sel_en   = en_w[cur_port];

  // Scan downward so the requester closest to the pointer overwrites the others.
  logic [2:0] win;
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_w[3'((int'(rr) + k) % N)]) win = 3'((int'(rr) + k) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr         <= '0;
      gnt        <= '0;
      cur_port   <= '0;
      ts_dout    <= '0;
      ts_dout_en <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
      wait_cnt   <= '0;
      gap_cnt    <= '0;
      trunc_done <= 1'b0;
    end else begin
      err        <= 1'b0;
      ts_dout    <= '0;
      ts_dout_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt      <= N'(1) << win;
            cur_port <= win;
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sel_en && sel_word[32]) begin
            ts_dout    <= sel_word;
            ts_dout_en <= 1'b1;
            word_cnt   <= WCW'(1);
            trunc_done <= 1'b0;
            state      <= ST_XFER;
          end else begin
            if (sel_en) err <= 1'b1;
            if (wait_cnt == TO_LAST) begin
              gnt     <= '0;
              err     <= 1'b1;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              wait_cnt <= wait_cnt + TCW'(1);
            end
          end
        end
        ST_XFER: begin
          if (sel_en && !sel_word[32]) begin
            if (word_cnt != LEN_MAX) begin
              ts_dout    <= sel_word;
              ts_dout_en <= 1'b1;
              word_cnt   <= word_cnt + WCW'(1);
            end else if (!trunc_done) begin
              err        <= 1'b1;
              trunc_done <= 1'b1;
            end
          end else begin
            // Either the burst ended or a stray SOF started another record: close this one.
            if (sel_en) err <= 1'b1;
            gnt     <= '0;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            rr    <= (cur_port == 3'(N - 1)) ? 3'd0 : cur_port + 3'd1;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TS_ARB_STAT_EN
  logic rec_done;
  assign rec_done = (state == ST_XFER) && (!sel_en || sel_word[32]);

  for (genvar gi = 0; gi < N; gi++) begin : g_stat
    logic [31:0] rec_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rec_reg <= '0;
      else if (rec_done && cur_port == 3'(gi)) rec_reg <= rec_reg + 32'd1;
    end
    assign rec_cnt[32*gi +: 32] = rec_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else if (err && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ts_merge_arb.sv
// Scoreboard bench for ts_merge_arb: requester drivers push expected words, a negedge monitor checks ts_dout.
module tb_ts_merge_arb;
  localparam int N = 4, TIMEOUT = 255, MAX_LEN = 400, GAP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    gnt;
  logic [33*N-1:0] din = '0;
  logic [N-1:0]    din_en = '0;
  logic [32:0]     ts_dout;
  logic            ts_dout_en;
  logic [2:0]      cur_port;
  logic            err;
`ifdef TS_ARB_STAT_EN
  logic [32*N-1:0] rec_cnt;
  logic [15:0]     drop_cnt;
`endif

  ts_merge_arb #(.N(N), .TIMEOUT(TIMEOUT), .MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .din(din), .din_en(din_en),
    .ts_dout(ts_dout), .ts_dout_en(ts_dout_en), .cur_port(cur_port), .err(err)
`ifdef TS_ARB_STAT_EN
    , .rec_cnt(rec_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int err_seen = 0, err_exp = 0;
  int rr_m = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops one expected word per valid output and checks the idle gap between records.
  logic prev_en = 1'b0;
  int   idle = 0;
  bit   seen = 1'b0;
  always @(negedge clk) begin
    if (err) err_seen++;
    if (ts_dout_en) begin
      if (!prev_en && seen) check("gap", 64'(idle >= GAP), 64'd1);
      seen = 1'b1;
      idle = 0;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %0h expected none", ts_dout);
      end else begin
        check("word", 64'(ts_dout), 64'(exp_q.pop_front()));
      end
    end else begin
      idle++;
      check("dout_zero", 64'(ts_dout), 64'd0);
    end
    prev_en = ts_dout_en;
  end

  function automatic int win_of(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(rr_m + k) % N]) return (rr_m + k) % N;
    return 0;
  endfunction

  function automatic logic [32:0] sof(input int p);
    return {1'b1, 24'd0, 8'(p)};
  endfunction

  task automatic grant(output int p);
    int e;
    int t;
    e = win_of(req);
    t = 0;
    while (gnt == '0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("gnt", 64'(gnt), 64'(1) << e);
    check("cur_port", 64'(cur_port), 64'(e));
    p = e;
    rr_m = (e + 1) % N;
  endtask

  task automatic send_rec(input int p, input int len, input int tail_sof);
    logic [32:0] w;
    for (int j = 0; j < len + tail_sof; j++) begin
      if (j == 0 || j == len) w = sof(p);
      else w = {1'b0, $urandom};
      din[33*p +: 33] = w;
      din_en[p] = 1'b1;
      if (j < len && j < MAX_LEN) exp_q.push_back(w);
      @(negedge clk);
    end
    din_en[p] = 1'b0;
    din[33*p +: 33] = '0;
    @(negedge clk);
    check("gnt_drop", 64'(gnt), 64'd0);
  endtask

  task automatic settle_err();
    repeat (4) @(negedge clk);
    check("err_cnt", 64'(err_seen), 64'(err_exp));
  endtask

  initial begin
    int p;
    int cnt;
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_en", 64'(ts_dout_en), 64'd0);
    check("rst_port", 64'(cur_port), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All requesters held: rotation from port 0.
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      grant(p);
      check("order", 64'(cur_port), 64'(r % 4));
      send_rec(p, 10, 0);
      $display("[TB] record %0d from port %0d done", r, p);
    end
    req = '0;
    settle_err();

    // Single requester, full 50-word record.
    req = 4'b0001;
    grant(p);
    send_rec(p, 50, 0);
    req = '0;
    settle_err();
    $display("[TB] 50-word record from port %0d done", p);

    // Timeout: port 2 never sends; req changes during WAIT.
    req = 4'b0100;
    grant(p);
    req = 4'b1001;
    cnt = 1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (gnt[2]) cnt++;
      else break;
    end
    check("timeout_len", 64'(cnt), 64'(TIMEOUT));
    err_exp++;
    grant(p);
    send_rec(p, 5, 0);
    req = '0;
    settle_err();
    $display("[TB] timeout on port 2, next grant port %0d", p);

    // Overlong burst truncated.
    req = 4'b0001;
    grant(p);
    send_rec(p, 410, 0);
    err_exp++;
    req = '0;
    settle_err();
    $display("[TB] 410-word burst on port %0d truncated", p);

    // Bad first word, then record ended by stray SOF; port 3 chatters meanwhile.
    req = 4'b0010;
    din[33*3 +: 33] = sof(3);
    din_en[3] = 1'b1;
    grant(p);
    din[33*p +: 33] = {1'b0, 32'hDEAD_BEEF};
    din_en[p] = 1'b1;
    @(negedge clk);
    din_en[p] = 1'b0;
    @(negedge clk);
    send_rec(p, 8, 1);
    err_exp += 2;
    din_en[3] = 1'b0;
    din[33*3 +: 33] = '0;
    req = '0;
    settle_err();
    $display("[TB] port %0d bad-SOF/stray-SOF record done", p);

    // Reset during transfer.
    req = 4'b0100;
    grant(p);
    for (int j = 0; j < 10; j++) begin
      din[33*p +: 33] = (j == 0) ? sof(p) : {1'b0, $urandom};
      din_en[p] = 1'b1;
      exp_q.push_back(din[33*p +: 33]);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    din_en = '0;
    #1;
    check("mid_rst_gnt", 64'(gnt), 64'd0);
    check("mid_rst_en", 64'(ts_dout_en), 64'd0);
    check("mid_rst_dout", 64'(ts_dout), 64'd0);
    check("mid_rst_port", 64'(cur_port), 64'd0);
    req = 4'b1001;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
`ifdef TS_ARB_STAT_EN
    check("rec_cnt_rst", 64'(rec_cnt[31:0]) | 64'(rec_cnt[95:64]), 64'd0);
    check("drop_cnt_rst", 64'(drop_cnt), 64'd0);
`endif
    grant(p);
    check("restart", 64'(cur_port), 64'd0);
    send_rec(p, 5, 0);
    req = '0;
    settle_err();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] reset recovery record from port %0d done", p);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
